// File: rtl/if_pkg.sv
// Shared definitions for the MIPS16e-style instruction-fetch stage and the decoder.
// Holds the fetch FSM encoding, the reset/bubble constants and the 5-bit major opcodes.
package if_pkg;

  localparam int unsigned IF_WORD_SIZE = 16;
  localparam logic [15:0] IF_RESET_PC  = 16'h0000;
  localparam logic [15:0] IF_NOP_CODE  = 16'h0800;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HELD  = 2'd2
  } state_t;

  // Major opcodes occupy code[15:11]; the decoder recodes from these.
  localparam logic [4:0] OP_ADDIUSP = 5'b00000;
  localparam logic [4:0] OP_NOP     = 5'b00001;
  localparam logic [4:0] OP_B       = 5'b00010;
  localparam logic [4:0] OP_JAL     = 5'b00011;
  localparam logic [4:0] OP_BEQZ    = 5'b00100;
  localparam logic [4:0] OP_BNEZ    = 5'b00101;
  localparam logic [4:0] OP_SHIFT   = 5'b00110;
  localparam logic [4:0] OP_ADDIU   = 5'b01001;
  localparam logic [4:0] OP_LI      = 5'b01101;
  localparam logic [4:0] OP_LW      = 5'b10011;
  localparam logic [4:0] OP_SW      = 5'b11011;
  localparam logic [4:0] OP_RRR     = 5'b11100;
  localparam logic [4:0] OP_RR      = 5'b11101;
  localparam logic [4:0] OP_EXTEND  = 5'b11110;

  function automatic logic [4:0] major_op(input logic [15:0] code);
    return code[15:11];
  endfunction

endpackage

// File: rtl/if_pc_next.sv
// Next-PC mux for the fetch stage: hold, pc+1, redirect target or pending delay-slot target.
// Optional macro IF_BRANCH_DELAY_SLOT_EN routes redirects through a pending target.
module if_pc_next
  import if_pkg::*;
#(
  parameter int unsigned WORD_SIZE = IF_WORD_SIZE
) (
  input  state_t               i_state,
  input  logic [WORD_SIZE-1:0] i_pc,
  input  logic                 i_ready,
  input  logic                 i_stall,
  input  logic                 i_redirect,
  input  logic [WORD_SIZE-1:0] i_redirect_pc,
`ifdef IF_BRANCH_DELAY_SLOT_EN
  input  logic                 i_pend_valid,
  input  logic [WORD_SIZE-1:0] i_pend_pc,
`endif
  output logic                 o_advance,
  output logic [WORD_SIZE-1:0] o_next_pc
);

  logic [WORD_SIZE-1:0] w_pc_inc;

  assign w_pc_inc  = i_pc + WORD_SIZE'(1);
  assign o_advance = !i_stall && ((i_state == S_FETCH && i_ready) || i_state == S_HELD);

  always_comb begin
    // NOTE: default assignment first so every path drives o_next_pc and no latch is inferred.
    o_next_pc = i_pc;
`ifdef IF_BRANCH_DELAY_SLOT_EN
    // The transfer in or after the redirect cycle is the delay slot; it steers pc to the target.
    if (o_advance) begin
      if (i_redirect)        o_next_pc = i_redirect_pc;
      else if (i_pend_valid) o_next_pc = i_pend_pc;
      else                   o_next_pc = w_pc_inc;
    end
`else
    if (i_redirect)     o_next_pc = i_redirect_pc;
    else if (o_advance) o_next_pc = w_pc_inc;
`endif
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC generation, req/ready imem access, skid buffer and IF/ID register.
// Optional macro IF_BRANCH_DELAY_SLOT_EN: redirects take effect after one delay-slot instruction.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter int unsigned          WORD_SIZE = IF_WORD_SIZE,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = IF_RESET_PC,
  parameter logic [WORD_SIZE-1:0] NOP_CODE  = IF_NOP_CODE
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req,
  output logic [WORD_SIZE-1:0] imem_addr,
  input  logic [WORD_SIZE-1:0] imem_rdata,
  input  logic                 imem_ready,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  output logic [WORD_SIZE-1:0] id_code,
  output logic [WORD_SIZE-1:0] id_pc,
  output logic                 id_valid
);

  state_t               r_state;
  logic [WORD_SIZE-1:0] r_pc;
  logic [WORD_SIZE-1:0] r_id_code;
  logic [WORD_SIZE-1:0] r_id_pc;
  logic                 r_id_valid;
  logic [WORD_SIZE-1:0] r_skid_code;
  logic [WORD_SIZE-1:0] r_skid_pc;
  logic                 w_advance;
  logic                 w_flush;
  logic [WORD_SIZE-1:0] w_next_pc;

`ifdef IF_BRANCH_DELAY_SLOT_EN
  logic                 r_pend_valid;
  logic [WORD_SIZE-1:0] r_pend_pc;

  assign w_flush = 1'b0;
`else
  assign w_flush = redirect;
`endif

  if_pc_next #(.WORD_SIZE(WORD_SIZE)) u_pc_next (
    .i_state       (r_state),
    .i_pc          (r_pc),
    .i_ready       (imem_ready),
    .i_stall       (stall),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
`ifdef IF_BRANCH_DELAY_SLOT_EN
    .i_pend_valid  (r_pend_valid),
    .i_pend_pc     (r_pend_pc),
`endif
    .o_advance     (w_advance),
    .o_next_pc     (w_next_pc)
  );

  assign imem_req  = (r_state == S_FETCH);
  assign imem_addr = r_pc;
  assign id_code   = r_id_code;
  assign id_pc     = r_id_pc;
  assign id_valid  = r_id_valid;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_BOOT;
      r_pc        <= RESET_PC;
      r_id_code   <= NOP_CODE;
      r_id_pc     <= '0;
      r_id_valid  <= 1'b0;
      r_skid_code <= '0;
      r_skid_pc   <= '0;
    end else begin
      r_pc <= w_next_pc;
      if (w_flush) begin
        // Any rdata returned this cycle belongs to the wrong path and is dropped.
        r_state    <= S_FETCH;
        r_id_code  <= NOP_CODE;
        r_id_valid <= 1'b0;
      end else begin
        case (r_state)
          S_BOOT: r_state <= S_FETCH;
          S_FETCH: begin
            if (w_advance) begin
              r_id_code  <= imem_rdata;
              r_id_pc    <= r_pc;
              r_id_valid <= 1'b1;
            end else if (imem_ready) begin
              r_skid_code <= imem_rdata;
              r_skid_pc   <= r_pc;
              r_state     <= S_HELD;
            end else if (!stall) begin
              r_id_code  <= NOP_CODE;
              r_id_valid <= 1'b0;
            end
          end
          S_HELD: begin
            if (w_advance) begin
              r_id_code  <= r_skid_code;
              r_id_pc    <= r_skid_pc;
              r_id_valid <= 1'b1;
              r_state    <= S_FETCH;
            end
          end
          default: r_state <= S_BOOT;
        endcase
      end
    end
  end

`ifdef IF_BRANCH_DELAY_SLOT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_valid <= 1'b0;
      r_pend_pc    <= '0;
    end else if (redirect && !w_advance) begin
      r_pend_valid <= 1'b1;
      r_pend_pc    <= redirect_pc;
    end else if (w_advance) begin
      r_pend_valid <= 1'b0;
    end
  end
`endif

  a_no_redirect_with_stall: assert property (@(posedge clk) disable iff (rst) !(redirect && stall));

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: streaming, ready stretch, stall/skid, redirect, PC wrap, reset.
// Expectations follow IF_BRANCH_DELAY_SLOT_EN when that macro is defined for the build.
module tb_if_fetch_stage;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] code;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ready = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [15:0] id_code;
  logic [15:0] id_pc;
  logic        id_valid;

  logic        w_req;
  logic [15:0] w_addr;
  logic [15:0] w_rdata;
  logic        w_ready = 1'b1;
  logic [15:0] w_id_code;
  logic [15:0] w_id_pc;
  logic        w_id_valid;

  int   n_total = 0;
  int   n_bad   = 0;
  exp_t exp_q[$];
  exp_t wrap_q[$];
  exp_t mon_e;
  exp_t wmon_e;

  always #5 clk = ~clk;

  // Instruction memory contents: word i holds 16'h4800 + i.
  assign imem_rdata = 16'h4800 + imem_addr;
  assign w_rdata    = 16'h4800 + w_addr;

  if_fetch_stage u_dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_code     (id_code),
    .id_pc       (id_pc),
    .id_valid    (id_valid)
  );

  if_fetch_stage #(.RESET_PC(16'hFFFE)) u_wrap (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (w_req),
    .imem_addr   (w_addr),
    .imem_rdata  (w_rdata),
    .imem_ready  (w_ready),
    .stall       (1'b0),
    .redirect    (1'b0),
    .redirect_pc (16'h0000),
    .id_code     (w_id_code),
    .id_pc       (w_id_pc),
    .id_valid    (w_id_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] pc);
    exp_t e;
    e.pc   = pc;
    e.code = 16'h4800 + pc;
    exp_q.push_back(e);
  endtask

  task automatic push_wrap(input logic [15:0] pc, input logic [15:0] code);
    exp_t e;
    e.pc   = pc;
    e.code = code;
    wrap_q.push_back(e);
  endtask

  // Returns 1 ns after the edge at which the DUT starts requesting address a.
  task automatic wait_addr(input logic [15:0] a);
    bit hit = 1'b0;
    for (int i = 0; i < 64 && !hit; i++) begin
      @(posedge clk);
      #1;
      hit = imem_req && (imem_addr == a);
    end
    check("reach_addr", {15'h0, imem_req, imem_addr}, {15'h0, 1'b1, a});
  endtask

  // The decoder consumes IF/ID on every cycle it is valid and not stalled.
  always @(negedge clk) begin
    if (!rst && id_valid && !stall) begin
      if (exp_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL unexpected_issue: got id_pc=%h id_code=%h, expected none", id_pc, id_code);
      end else begin
        mon_e = exp_q.pop_front();
        check("issue_pc", {16'h0, id_pc}, {16'h0, mon_e.pc});
        check("issue_code", {16'h0, id_code}, {16'h0, mon_e.code});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && w_id_valid) begin
      if (wrap_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL wrap_unexpected_issue: got id_pc=%h, expected none", w_id_pc);
      end else begin
        wmon_e = wrap_q.pop_front();
        check("wrap_pc", {16'h0, w_id_pc}, {16'h0, wmon_e.pc});
        check("wrap_code", {16'h0, w_id_code}, {16'h0, wmon_e.code});
      end
    end
  end

  // Wrap instance: deliver FFFE, FFFF, 0000 then starve it of ready.
  initial begin
    bit seen = 1'b0;
    push_wrap(16'hFFFE, 16'h47FE);
    push_wrap(16'hFFFF, 16'h47FF);
    push_wrap(16'h0000, 16'h4800);
    @(negedge rst);
    for (int i = 0; i < 32 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = w_req && (w_addr == 16'h0001);
    end
    w_ready = 1'b0;
    check("wrap_reach_0001", {31'h0, seen}, 32'h1);
  end

  initial begin
    #1 rst = 1'b1;
    #10;
    check("rst_req",   {31'h0, imem_req}, 32'h0);
    check("rst_addr",  {16'h0, imem_addr}, 32'h0000);
    check("rst_code",  {16'h0, id_code}, 32'h0800);
    check("rst_pc",    {16'h0, id_pc}, 32'h0000);
    check("rst_valid", {31'h0, id_valid}, 32'h0);

    for (int i = 0; i < 5; i++) push(16'(i));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("boot_valid", {31'h0, id_valid}, 32'h0);
    check("boot_req",   {31'h0, imem_req}, 32'h1);
    @(posedge clk);
    #1;
    check("first_valid", {31'h0, id_valid}, 32'h1);

    // Ready stretched at address 5: three bubbles, address held.
    wait_addr(16'h0005);
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("stretch_addr",  {16'h0, imem_addr}, 32'h0005);
      check("stretch_req",   {31'h0, imem_req}, 32'h1);
      check("stretch_valid", {31'h0, id_valid}, 32'h0);
      check("stretch_code",  {16'h0, id_code}, 32'h0800);
    end
    imem_ready = 1'b1;
    for (int i = 5; i < 10; i++) push(16'(i));

    // Stall at address 8: IF/ID holds 7, skid holds 8, request dropped.
    wait_addr(16'h0008);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("stall_id_pc", {16'h0, id_pc}, 32'h0007);
      check("stall_valid", {31'h0, id_valid}, 32'h1);
      check("stall_req",   {31'h0, imem_req}, 32'h0);
    end
    stall = 1'b0;
    push(16'h000A);
    push(16'h000B);

    // Redirect to 0x0040 while address 12 is on the bus.
    wait_addr(16'h000C);
`ifdef IF_BRANCH_DELAY_SLOT_EN
    push(16'h000C);
`endif
    push(16'h0040);
    push(16'h0041);
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    check("redir_addr", {16'h0, imem_addr}, 32'h0040);
`ifndef IF_BRANCH_DELAY_SLOT_EN
    check("redir_flush_valid", {31'h0, id_valid}, 32'h0);
    check("redir_flush_code",  {16'h0, id_code}, 32'h0800);
`endif

    // Two back-to-back redirects while the request at 0x42 is stretched.
    wait_addr(16'h0042);
    imem_ready = 1'b0;
    @(posedge clk);
    #1;
    redirect    = 1'b1;
    redirect_pc = 16'h0080;
    @(posedge clk);
    #1;
    redirect_pc = 16'h0090;
    @(posedge clk);
    #1;
    redirect   = 1'b0;
`ifdef IF_BRANCH_DELAY_SLOT_EN
    check("pend_addr", {16'h0, imem_addr}, 32'h0042);
    push(16'h0042);
`else
    check("pend_addr", {16'h0, imem_addr}, 32'h0090);
`endif
    push(16'h0090);
    push(16'h0091);
    imem_ready = 1'b1;

    wait_addr(16'h0092);
    imem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);
    check("wrap_queue_drained", wrap_q.size(), 32'd0);
    check("pre_rst_req", {31'h0, imem_req}, 32'h1);

    // Asynchronous reset mid-request.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_req",   {31'h0, imem_req}, 32'h0);
    check("mid_rst_addr",  {16'h0, imem_addr}, 32'h0000);
    check("mid_rst_valid", {31'h0, id_valid}, 32'h0);
    check("mid_rst_code",  {16'h0, id_code}, 32'h0800);
    check("mid_rst_pc",    {16'h0, id_pc}, 32'h0000);
    check("mid_rst_wrap_addr", {16'h0, w_addr}, 32'hFFFE);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
